// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle input path: direction state encoding,
// the {up,down,left,right} bit positions and the visible screen size.
package paddle_pkg;

   typedef enum logic [2:0] {
      ST_NONE  = 3'd0,
      ST_UP    = 3'd1,
      ST_DOWN  = 3'd2,
      ST_LEFT  = 3'd3,
      ST_RIGHT = 3'd4
   } dir_state_t;

   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   // Fixed priority up > down > left > right; all-zero resolves to no direction.
   function automatic dir_state_t dir_prio(input logic [3:0] v);
      if (v[DIR_UP])         return ST_UP;
      else if (v[DIR_DOWN])  return ST_DOWN;
      else if (v[DIR_LEFT])  return ST_LEFT;
      else if (v[DIR_RIGHT]) return ST_RIGHT;
      else                   return ST_NONE;
   endfunction

endpackage

// File: rtl/paddle_input_ctrl_if.sv
// Video timing, raw buttons and the resolved direction/move outputs of the
// paddle input controller, bundled for connection to the paddle tracker side.
interface paddle_input_ctrl_if;
   logic       pixpulse;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic       move;

   modport master (
      output pixpulse, hcount, vcount, btn_up, btn_down, btn_left, btn_right,
      input  up, down, left, right, move
   );

   modport slave (
      input  pixpulse, hcount, vcount, btn_up, btn_down, btn_left, btn_right,
      output up, down, left, right, move
   );
endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, consecutive-cycle debounce counter and
// single-cycle rise/fall flags that coincide with the debounced state change.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_state,
   output logic o_rise,
   output logic o_fall
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_state;
   logic          r_rise;
   logic          r_fall;
   logic          w_sync;

   assign w_sync = r_sync[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_state <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (w_sync == r_state) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
            r_cnt   <= '0;
            r_state <= w_sync;
            r_rise  <= w_sync;
            r_fall  <= ~w_sync;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_state = r_state;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
endmodule

// File: rtl/paddle_input_ctrl.sv
// Paddle input controller: debounces four buttons, resolves a last-pressed-wins
// direction and publishes it once per MOVE_DIV frames with a move strobe.
//
// state    | meaning
// S_NONE   | no button held, paddle idle
// S_UP     | up is the active direction
// S_DOWN   | down is the active direction
// S_LEFT   | left is the active direction
// S_RIGHT  | right is the active direction
module paddle_input_ctrl
   import paddle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int MOVE_DIV        = 1,
   parameter int FRAME_LINE      = 480
) (
   input logic                clk,
   input logic                rst,
   paddle_input_ctrl_if.slave bus
);
   localparam logic [2:0] S_NONE  = ST_NONE;
   localparam logic [2:0] S_UP    = ST_UP;
   localparam logic [2:0] S_DOWN  = ST_DOWN;
   localparam logic [2:0] S_LEFT  = ST_LEFT;
   localparam logic [2:0] S_RIGHT = ST_RIGHT;

   logic [3:0] w_raw;
   logic [3:0] w_held;
   logic [3:0] w_rise;
   logic [3:0] w_fall;
   logic [3:0] w_state_oh;
   logic [2:0] w_state_nxt;
   logic       w_tick;
   logic       w_terminal;

   logic [2:0] r_state;
   logic [7:0] r_frame_cnt;
   logic [3:0] r_dir;
   logic       r_pending;

   assign w_raw[DIR_UP]    = bus.btn_up;
   assign w_raw[DIR_DOWN]  = bus.btn_down;
   assign w_raw[DIR_LEFT]  = bus.btn_left;
   assign w_raw[DIR_RIGHT] = bus.btn_right;

   for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .rst    (rst),
         .i_btn  (w_raw[gi]),
         .o_state(w_held[gi]),
         .o_rise (w_rise[gi]),
         .o_fall (w_fall[gi])
      );
   end

   always_comb begin
      w_state_oh = '0;
      case (r_state)
         S_UP:    w_state_oh[DIR_UP]    = 1'b1;
         S_DOWN:  w_state_oh[DIR_DOWN]  = 1'b1;
         S_LEFT:  w_state_oh[DIR_LEFT]  = 1'b1;
         S_RIGHT: w_state_oh[DIR_RIGHT] = 1'b1;
         default: w_state_oh = '0;
      endcase
   end

   // A new press always wins; losing the active button falls back to whatever
   // is still held, which already excludes the button that just fell.
   always_comb begin
      w_state_nxt = r_state;
      if (|w_rise) begin
         w_state_nxt = dir_prio(w_rise);
      end else if (|(w_fall & w_state_oh)) begin
         w_state_nxt = dir_prio(w_held);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_NONE;
      else      r_state <= w_state_nxt;
   end

   assign w_tick     = bus.pixpulse && (bus.hcount == '0) && (bus.vcount == 10'(FRAME_LINE));
   assign w_terminal = w_tick && (r_frame_cnt == 8'(MOVE_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_cnt <= '0;
         r_dir       <= '0;
         r_pending   <= 1'b0;
      end else begin
         if (w_tick) begin
            r_frame_cnt <= w_terminal ? 8'd0 : r_frame_cnt + 8'd1;
         end
         if (w_terminal) begin
            r_dir     <= w_state_oh;
            r_pending <= (r_state != S_NONE);
         end else if (r_pending && bus.pixpulse) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign bus.up    = r_dir[DIR_UP];
   assign bus.down  = r_dir[DIR_DOWN];
   assign bus.left  = r_dir[DIR_LEFT];
   assign bus.right = r_dir[DIR_RIGHT];
   // The strobe is the pixpulse itself, gated by a pending move.
   assign bus.move  = r_pending && bus.pixpulse;
endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl: two instances (MOVE_DIV 1 and 3) on a
// shrunken video raster, scoreboarded against expected direction and move cycles.
module tb_paddle_input_ctrl;
   localparam int DB    = 8;
   localparam int FL    = 6;
   localparam int H_TOT = 10;
   localparam int V_TOT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pixpulse = 1'b0;
   logic [9:0] hcount = '0;
   logic [9:0] vcount = '0;
   logic       b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [3:0] exp_dir = 4'b0000;
   logic [3:0] cur0 = '0, cur1 = '0, nxt0 = '0, nxt1 = '0;
   bit         tick_prev = 1'b0;
   int         fc1 = 0;
   int         q0[$];
   int         q1[$];

   paddle_input_ctrl_if if0 ();
   paddle_input_ctrl_if if1 ();

   assign if0.pixpulse  = pixpulse;
   assign if0.hcount    = hcount;
   assign if0.vcount    = vcount;
   assign if0.btn_up    = b_up;
   assign if0.btn_down  = b_down;
   assign if0.btn_left  = b_left;
   assign if0.btn_right = b_right;
   assign if1.pixpulse  = pixpulse;
   assign if1.hcount    = hcount;
   assign if1.vcount    = vcount;
   assign if1.btn_up    = b_up;
   assign if1.btn_down  = b_down;
   assign if1.btn_left  = b_left;
   assign if1.btn_right = b_right;

   paddle_input_ctrl #(.DEBOUNCE_CYCLES(DB), .MOVE_DIV(1), .FRAME_LINE(FL)) u_dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave)
   );
   paddle_input_ctrl #(.DEBOUNCE_CYCLES(DB), .MOVE_DIV(3), .FRAME_LINE(FL)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Raster: pixpulse every 4th clk, counters advance after each pixpulse cycle.
   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge clk);
         #1;
         if (pixpulse) begin
            if (hcount == 10'(H_TOT - 1)) begin
               hcount = '0;
               vcount = (vcount == 10'(V_TOT - 1)) ? 10'd0 : vcount + 10'd1;
            end else begin
               hcount = hcount + 10'd1;
            end
         end
         phase    = (phase + 1) % 4;
         pixpulse = (phase == 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: ticks push expected move cycles, strobes pop and compare them.
   always @(negedge clk) begin
      if (!rst) begin
         cur0 = '0;
         cur1 = '0;
         tick_prev = 1'b0;
         fc1 = 0;
         q0.delete();
         q1.delete();
      end else if (tick_prev) begin
         cur0 = nxt0;
         cur1 = nxt1;
         tick_prev = 1'b0;
      end
      check("dir0", {28'd0, if0.up, if0.down, if0.left, if0.right}, {28'd0, cur0});
      check("dir1", {28'd0, if1.up, if1.down, if1.left, if1.right}, {28'd0, cur1});

      if (if0.move === 1'b1) begin
         if (q0.size() == 0) check("move0_unexpected", 1, 0);
         else begin
            check("move0_cycle", cyc, q0.pop_front());
            check("move0_pixpulse", {31'd0, pixpulse}, 1);
         end
      end else if (q0.size() > 0 && q0[0] < cyc) begin
         check("move0_missed", cyc, q0.pop_front());
      end
      if (if1.move === 1'b1) begin
         if (q1.size() == 0) check("move1_unexpected", 1, 0);
         else begin
            check("move1_cycle", cyc, q1.pop_front());
            check("move1_pixpulse", {31'd0, pixpulse}, 1);
         end
      end else if (q1.size() > 0 && q1[0] < cyc) begin
         check("move1_missed", cyc, q1.pop_front());
      end

      if (rst && pixpulse && hcount == 10'd0 && vcount == 10'(FL)) begin
         tick_prev = 1'b1;
         nxt0 = exp_dir;
         if (exp_dir != 4'b0000) q0.push_back(cyc + 4);
         nxt1 = cur1;
         if (fc1 == 2) begin
            fc1 = 0;
            nxt1 = exp_dir;
            if (exp_dir != 4'b0000) q1.push_back(cyc + 4);
         end else begin
            fc1++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns two cycles after the next frame tick.
   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
         if (n > 2000) begin
            n_fail++;
            $display("FAIL tick_timeout waited=%0d limit=2000", n);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $fatal(1, "no frame tick");
         end
      end while (!(pixpulse && hcount == 10'd0 && vcount == 10'(FL)));
      step(2);
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         {b_up, b_down, b_left, b_right} = 4'($urandom);
      end
      check("rst_move0", {31'd0, if0.move}, 0);
      check("rst_dir0", {28'd0, if0.up, if0.down, if0.left, if0.right}, 0);
      {b_up, b_down, b_left, b_right} = 4'b0000;
      step(3);
      rst = 1'b1;
      repeat (3) wait_tick();

      // single direction; instance 1 strobes every third frame
      b_up = 1'b1;
      step(30);
      exp_dir = 4'b1000;
      repeat (6) wait_tick();

      // up released while right pressed in the same cycle: the rise wins
      b_up = 1'b0;
      b_right = 1'b1;
      step(30);
      exp_dir = 4'b0001;
      wait_tick();
      b_up = 1'b1;
      step(30);
      exp_dir = 4'b1000;
      wait_tick();
      b_up = 1'b0;
      step(30);
      exp_dir = 4'b0001;
      wait_tick();
      b_right = 1'b0;
      step(30);
      exp_dir = 4'b0000;
      repeat (2) wait_tick();

      // simultaneous press, then release of the non-active button
      b_down = 1'b1;
      b_left = 1'b1;
      step(30);
      exp_dir = 4'b0100;
      wait_tick();
      b_left = 1'b0;
      step(30);
      wait_tick();
      b_down = 1'b0;
      step(30);
      exp_dir = 4'b0000;
      repeat (3) wait_tick();

      // bounce shorter than the debounce window
      repeat (10) begin
         b_left = 1'b1;
         step(5);
         b_left = 1'b0;
         step(3);
      end
      step(20);
      repeat (3) wait_tick();

      // reset two cycles after a terminal tick that left a move pending
      b_up = 1'b1;
      step(30);
      exp_dir = 4'b1000;
      wait_tick();
      rst = 1'b0;
      b_up = 1'b0;
      exp_dir = 4'b0000;
      step(6);
      check("rstmid_move0", {31'd0, if0.move}, 0);
      check("rstmid_dir0", {28'd0, if0.up, if0.down, if0.left, if0.right}, 0);
      rst = 1'b1;
      repeat (3) wait_tick();

      step(10);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/paddle_input_ctrl.md
# paddle_input_ctrl

Upstream control stage for the paddle. It synchronises and debounces the four raw push-buttons and resolves them into a single active direction, using a last-pressed-wins rule. Once per N video frames it presents a one-hot `{up,down,left,right}` code and a one-cycle `move` strobe aligned to `pixpulse`. The paddle tracker consumes both directly, so it only ever sees legal single-direction codes that stay stable for a whole frame.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive `clk` cycles a synchronised input must differ from its debounced state before that state flips (10 ms at 100 MHz).
- `MOVE_DIV`, 1: frames per move opportunity; range 1..255.
- `FRAME_LINE`, 480: `vcount` value marking the frame tick (start of vertical blank).
- `clk`  in  1  100 MHz system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `pixpulse`  in  1  1-cycle enable, every 4th `clk`.
- `hcount`  in  10  current pixel x.
- `vcount`  in  10  current pixel y.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw, asynchronous, bouncy buttons.
- `up`, `down`, `left`, `right`  out  1 each  latched direction; one-hot or all-zero.
- `move`  out  1  move strobe, high for exactly one `clk` cycle, coincident with `pixpulse`.

## Operation
- **Synchroniser:** 2-flop chain per button.
- **Debounce:** per-button counter, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Counter clears whenever the synchronised input equals the debounced state.
  - Counter increments while the two differ.
  - On reaching `DEBOUNCE_CYCLES`, the debounced state toggles and the counter clears.
  - Rising/falling edge flags are 1-cycle pulses.
- **Direction FSM:** states S_NONE, S_UP, S_DOWN, S_LEFT, S_RIGHT.
  - Any debounced rising edge moves the FSM to that button's state (last-pressed wins).
  - Several rising edges in the same cycle resolve by priority up > down > left > right.
  - A falling edge of the active button moves the FSM to the highest-priority button still held, or to S_NONE if none is held.
  - A falling edge of a non-active button is ignored.
  - Simultaneous rise and fall in one cycle: the rise is applied.
- **Frame tick:** the cycle where `pixpulse && hcount==0 && vcount==FRAME_LINE`.
  - An 8-bit frame counter counts ticks and wraps at `MOVE_DIV-1`.
  - On a terminal tick, the direction outputs load the one-hot decode of the FSM state (S_NONE → all 0), and `pending` is set if the state is not S_NONE.
  - On any non-terminal tick, the outputs hold.
- **Move strobe:** when `pending` is set, `move` asserts on the next `pixpulse` cycle, then `pending` clears.
  - No move is ever issued for S_NONE. This avoids needless neighbour-scan clears in the paddle.
- **Reset:** asserting `rst` at any time clears everything, including any pending move. Reset values: `up`/`down`/`left`/`right`/`move` = 0, debounced states 0, counters 0, FSM S_NONE, `pending` 0.

## Timing
- Button to debounced edge: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 register cycle.
- Debounced edge to FSM state: 1 cycle.
- FSM to outputs: sampled on the next terminal frame tick only.
- Direction outputs change only on a terminal tick cycle and are stable for at least `MOVE_DIV` frames.
- `move` rises exactly 4 `clk` cycles after the terminal tick (the next `pixpulse`) and is high for 1 cycle. At most one `move` per `MOVE_DIV` frames.
- FSM changes between a tick and its `move` do not alter the latched direction.
- A glitch shorter than `DEBOUNCE_CYCLES` never changes debounced state.

## Structure
- **Shared package `paddle_pkg`:**
  - direction state encoding (`dir_state_t`: NONE/UP/DOWN/LEFT/RIGHT);
  - the `{up,down,left,right}` bit-order constants (DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0);
  - screen constants H_ACTIVE=640 and V_ACTIVE=480.
- **Sub-module `btn_debounce`:** synchroniser, debounce counter and edge flags; parameter `DEBOUNCE_CYCLES`; instantiated four times.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=8 and `MOVE_DIV`=1 unless stated.
- **Reset and idle:** `rst`=0 for 10 cycles with buttons toggling → all outputs 0. Release `rst`, no buttons, 3 frames → `move` never 1.
- **Single direction, divider:** `btn_up` held → from the first tick after debounce, `{up,down,left,right}`=4'b1000 and `move` is 1 for one cycle, 4 clk after each tick, with `pixpulse`=1. Repeat with `MOVE_DIV`=3 → `move` every 3rd frame only.
- **Bounce rejection:** `btn_left` pulses high for 5 cycles, low 3, ×10 → debounced never rises, outputs 0, no `move`.
- **Last-pressed wins:**
  - hold `btn_right`, then press `btn_up` → next tick 4'b1000;
  - release `btn_up` with right held → next tick 4'b0001;
  - release right → 4'b0000 and no `move`.
- **Simultaneous press:** `btn_down` and `btn_left` rise in the same cycle → 4'b0100.
- **Reset mid-operation:** assert `rst` 2 cycles after a terminal tick with `pending` set → no `move` pulse, outputs 0, FSM S_NONE after release.
